data_cal_sweep: RTL and testbench
=================================

# data_cal_sweep

Parametrised successor of the nibble-sum calculator. Buffers a packed word of `FIELDS` fields and returns field 0 combined with a selected field. Also supports a load-and-sweep command that streams all `FIELDS-1` results on consecutive cycles. Sits on the same datapath slot as the fixed 16-bit/4-field calculator and adds a valid qualifier, a busy indication and a result index.

## Interface
- `FIELD_W`, 4, width of one field in bits (≥2)
- `FIELDS`, 4, number of packed fields; power of two, ≥2
- Derived (localparam, not overridable): `DATA_W = FIELD_W*FIELDS`, `SEL_W = $clog2(FIELDS)`
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `in_valid`  in  1  command strobe; sampled only when `busy`=0
- `d`  in  DATA_W  packed word; field k = `d[k*FIELD_W +: FIELD_W]`
- `sel`  in  SEL_W  0 = load `d` into buffer; k≠0 = compute with field k
- `sweep`  in  1  1 = load `d` and sweep fields 1..FIELDS-1; overrides `sel`
- `op`  in  1  0 = sum, 1 = absolute difference (only with macro; see Configuration)
- `out`  out  FIELD_W+1  registered result
- `validout`  out  1  `out` holds a valid result this cycle
- `out_idx`  out  SEL_W  field index k that produced `out`
- `busy`  out  1  sweep in progress; commands ignored

## Operation
- Buffer `tmp` (DATA_W bits) is written only by a load (`sel`=0, `sweep`=0) or a sweep command.
- FSM states: IDLE, SWEEP. `busy` = (state==SWEEP), decoded from the state register.
- IDLE, `in_valid`=0: `validout`←0, `out`←0, `out_idx`←0.
- IDLE, `in_valid`=1, `sweep`=0, `sel`=0:
  - `tmp`←`d`
  - `validout`←0, `out`←0, `out_idx`←0
- IDLE, `in_valid`=1, `sweep`=0, `sel`=k≠0:
  - `out`←f(tmp[0], tmp[k]), `out_idx`←k, `validout`←1
  - `tmp` unchanged
- IDLE, `in_valid`=1, `sweep`=1 (`sel` ignored):
  - `tmp`←`d`
  - `out`←f(d[0], d[1]), `out_idx`←1, `validout`←1
  - If FIELDS>2: counter `cnt`←2 and state→SWEEP. Otherwise stay in IDLE.
- SWEEP, each edge:
  - `out`←f(tmp[0], tmp[cnt]), `out_idx`←`cnt`, `validout`←1
  - If `cnt`==FIELDS-1: state→IDLE. Otherwise `cnt`←`cnt`+1.
  - `in_valid`, `d`, `sel`, `sweep`, `op` are ignored in this state.
- `op` is sampled once with the sweep command, held for the whole sweep, and applies to all results.
- Arithmetic:
  - Sum: `{1'b0,a}+{1'b0,b}` in FIELD_W+1 bits; never overflows.
  - Abs diff: `a≥b ? a-b : b-a`, zero-extended; MSB always 0.
- `out` is forced to 0 in every cycle where `validout`=0.

## Timing
- Reset (`rst`=1 at an edge): on that edge `out`=0, `validout`=0, `out_idx`=0, `busy`=0, `tmp`=0, `cnt`=0, state=IDLE.
- Reset has priority over every other input, including mid-sweep; the sweep is abandoned and no further results are produced.
- Single-op latency: command sampled at edge E, result visible from E until the next edge (1 cycle).
- Sweep: command at edge E0 produces idx 1 after E0, idx 2 after E1, …, idx FIELDS-1 after E(FIELDS-2).
- `busy`=1 from E0 through E(FIELDS-2). The earliest next accepted command is at E(FIELDS-1).
- Back-to-back single ops are accepted every cycle. A load followed by a compute on the next cycle uses the newly loaded data.

## Configuration
- Macro: `DATA_CAL_SWEEP_ABSDIFF_EN`.
- Defined: `op`=1 selects absolute difference; `op`=0 selects sum.
- Undefined: the `op` port is still present but ignored; all results are sums, and the difference logic is not synthesised.

## Test plan
(FIELD_W=4, FIELDS=4, macro defined unless noted)
- Reset mid-sweep: `rst`=1 one edge after a sweep command → `out`=0, `validout`=0, `busy`=0, `out_idx`=0 on that edge; no further valid results.
- Load and compute: load `d`=16'hF8E9, then `sel`=1,2,3 with `op`=0 → `out`=5'h17, 5'h11, 5'h18 on consecutive cycles, `out_idx`=1,2,3, `validout`=1.
- Load only: load cycle with `sel`=0 → `validout`=0, `out`=0. Idle cycles between computes → `validout`=0 and `out`=0.
- Sum sweep: `sweep`=1, `d`=16'h1234, `op`=0 → outputs 7, 6, 5 on three consecutive cycles with `out_idx` 1, 2, 3; `busy`=1 for exactly two cycles. An `in_valid` pulse (`sel`=1) during `busy` produces no extra result.
- Difference sweep: `sweep`=1, `d`=16'h1234, `op`=1 → outputs 1, 2, 3. Same stimulus with the macro undefined → outputs 7, 6, 5.
- Sweep reload: sweep on 16'h1234, then `sel`=2 compute → `out`=6, confirming the sweep reloaded `tmp`.

Source files
------------

// File: rtl/data_cal_sweep.sv
// Field calculator: buffers a packed word of FIELDS fields and returns field 0
// combined with a selected field, or sweeps fields 1..FIELDS-1 on consecutive cycles.
// Optional feature macro: DATA_CAL_SWEEP_ABSDIFF_EN enables op=1 absolute difference.

module data_cal_sweep_alu #(
    parameter int FIELD_W = 4
) (
    input  logic [FIELD_W-1:0] a,
    input  logic [FIELD_W-1:0] b,
    input  logic               op,
    output logic [FIELD_W:0]   res
);
`ifdef DATA_CAL_SWEEP_ABSDIFF_EN
    always_comb begin
        res = {1'b0, a} + {1'b0, b};
        if (op) res = (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    end
`else
    logic unused_op;
    assign unused_op = op;
    assign res = {1'b0, a} + {1'b0, b};
`endif
endmodule

module data_cal_sweep #(
    parameter int FIELD_W = 4,
    parameter int FIELDS  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic [FIELD_W*FIELDS-1:0]          d,
    input  logic [$clog2(FIELDS)-1:0]          sel,
    input  logic                               sweep,
    input  logic                               op,
    output logic [FIELD_W:0]                   out,
    output logic                               validout,
    output logic [$clog2(FIELDS)-1:0]          out_idx,
    output logic                               busy
);
    localparam int DATA_W = FIELD_W * FIELDS;
    localparam int SEL_W  = $clog2(FIELDS);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(FIELDS - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    logic [0:0]        state;
    logic [DATA_W-1:0] tmp;
    logic [SEL_W-1:0]  cnt;
    logic              op_q;

    logic [FIELDS-1:0][FIELD_W-1:0] tmp_f;
    logic [FIELDS-1:0][FIELD_W-1:0] d_f;
    assign tmp_f = tmp;
    assign d_f   = d;

    logic [FIELD_W-1:0] alu_a, alu_b;
    logic               alu_op;
    logic [FIELD_W:0]   alu_res;

    // A sweep command computes from the incoming word, since tmp is written on the same edge.
    always_comb begin
        alu_a  = tmp_f[0];
        alu_b  = tmp_f[sel];
        alu_op = op;
        if (state == SWEEP) begin
            alu_b  = tmp_f[cnt];
            alu_op = op_q;
        end else if (sweep) begin
            alu_a = d_f[0];
            alu_b = d_f[1];
        end
    end

    data_cal_sweep_alu #(.FIELD_W(FIELD_W)) u_alu (
        .a   (alu_a),
        .b   (alu_b),
        .op  (alu_op),
        .res (alu_res)
    );

    assign busy = (state == SWEEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tmp      <= '0;
            cnt      <= '0;
            op_q     <= 1'b0;
            out      <= '0;
            validout <= 1'b0;
            out_idx  <= '0;
        end else begin
            out      <= '0;
            validout <= 1'b0;
            out_idx  <= '0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (sweep) begin
                            tmp      <= d;
                            op_q     <= op;
                            out      <= alu_res;
                            out_idx  <= SEL_W'(1);
                            validout <= 1'b1;
                            if (FIELDS > 2) begin
                                cnt   <= SEL_W'(2);
                                state <= SWEEP;
                            end
                        end else if (sel == '0) begin
                            tmp <= d;
                        end else begin
                            out      <= alu_res;
                            out_idx  <= sel;
                            validout <= 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    out      <= alu_res;
                    out_idx  <= cnt;
                    validout <= 1'b1;
                    if (cnt == LAST) state <= IDLE;
                    else             cnt   <= cnt + SEL_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_cal_sweep.sv
// Directed table-driven bench for data_cal_sweep (FIELD_W=4, FIELDS=4), plus
// hand-written sweep sequences with bounded waits.
module tb_data_cal_sweep;
    logic        clk = 1'b0;
    logic        rst, in_valid, sweep, op;
    logic [15:0] d;
    logic [1:0]  sel;
    logic [4:0]  out;
    logic        validout, busy;
    logic [1:0]  out_idx;

    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_cal_sweep #(.FIELD_W(4), .FIELDS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .d(d), .sel(sel),
        .sweep(sweep), .op(op), .out(out), .validout(validout),
        .out_idx(out_idx), .busy(busy)
    );

`ifdef DATA_CAL_SWEEP_ABSDIFF_EN
    localparam logic [4:0] D1 = 5'd1, D2 = 5'd2, D3 = 5'd3, DF2 = 5'h0D;
`else
    localparam logic [4:0] D1 = 5'd7, D2 = 5'd6, D3 = 5'd5, DF2 = 5'h11;
`endif

    typedef struct {
        logic        rst, iv, sw, op;
        logic [1:0]  sel;
        logic [15:0] d;
        logic [4:0]  e_out;
        logic        e_v;
        logic [1:0]  e_idx;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic iv, logic sw, logic o, logic [1:0] s,
                                logic [15:0] dd, logic [4:0] eo, logic ev,
                                logic [1:0] ei, logic eb);
        vec_t v;
        v.rst = r; v.iv = iv; v.sw = sw; v.op = o; v.sel = s; v.d = dd;
        v.e_out = eo; v.e_v = ev; v.e_idx = ei; v.e_busy = eb;
        return v;
    endfunction

    task automatic check(string name, logic [4:0] eo, logic ev, logic [1:0] ei, logic eb);
        applied++;
        if (out !== eo || validout !== ev || out_idx !== ei || busy !== eb) begin
            miscompares++;
            $display("FAIL %s: got out=%h v=%b idx=%0d busy=%b, want out=%h v=%b idx=%0d busy=%b",
                     name, out, validout, out_idx, busy, eo, ev, ei, eb);
        end
    endtask

    task automatic drive(logic r, logic iv, logic sw, logic o, logic [1:0] s, logic [15:0] dd);
        @(negedge clk);
        rst = r; in_valid = iv; sweep = sw; op = o; sel = s; d = dd;
    endtask

    // Sweep from IDLE, then follow busy with a cycle budget.
    task automatic hand_sweep(string name, logic [15:0] dd, logic o,
                              logic [4:0] e1, logic [4:0] e2, logic [4:0] e3);
        logic [4:0] exp_o [4];
        int n;
        exp_o[1] = e1; exp_o[2] = e2; exp_o[3] = e3; exp_o[0] = 5'd0;
        drive(1'b0, 1'b1, 1'b1, o, 2'd2, dd);
        @(posedge clk); #1;
        check({name, "_first"}, e1, 1'b1, 2'd1, 1'b1);
        drive(1'b0, 1'b1, 1'b0, ~o, 2'd3, 16'hFFFF);
        n = 0;
        while (busy && n < 8) begin
            @(posedge clk); #1;
            n++;
            check({name, "_step"}, exp_o[(n + 1) % 4], 1'b1, 2'((n + 1) % 4), (n == 1));
        end
        applied++;
        if (n != 2 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_len: busy extra cycles=%0d busy=%b, want 2 and 0", name, n, busy);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        @(posedge clk); #1;
        check({name, "_after"}, 5'd0, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; sweep = 1'b0; op = 1'b0; sel = 2'd0; d = 16'h0;

        //            rst iv sw op sel d         out    v  idx  busy
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 5'h00, 0, 0, 0)); // reset
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'hF8E9, 5'h00, 0, 0, 0)); // load
        vecs.push_back(mk(0, 1, 0, 0, 1, 16'h0000, 5'h17, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2, 16'h0000, 5'h11, 1, 2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 3, 16'h0000, 5'h18, 1, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 5'h00, 0, 0, 0)); // idle
        vecs.push_back(mk(0, 1, 0, 0, 1, 16'h0000, 5'h17, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 5'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 3, 16'h1234, 5'd7,  1, 1, 1)); // sum sweep
        vecs.push_back(mk(0, 1, 0, 0, 1, 16'h0000, 5'd6,  1, 2, 1)); // ignored pulse
        vecs.push_back(mk(0, 1, 1, 1, 1, 16'hFFFF, 5'd5,  1, 3, 0)); // ignored sweep
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 5'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2, 16'h0000, 5'd6,  1, 2, 0)); // sweep reloaded tmp
        vecs.push_back(mk(0, 1, 1, 1, 0, 16'h1234, D1,    1, 1, 1)); // diff sweep
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, D2,    1, 2, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, D3,    1, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 5'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h1234, 5'd7,  1, 1, 1)); // sweep, then reset
        vecs.push_back(mk(1, 1, 0, 0, 1, 16'h0000, 5'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 5'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 5'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 16'h0000, 5'h00, 1, 1, 0)); // tmp cleared by reset
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h00F2, 5'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 16'h0000, DF2,   1, 1, 0)); // single-op diff, b>a
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'hFFFF, 5'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 3, 16'h0000, 5'h1E, 1, 3, 0)); // max sum
        vecs.push_back(mk(0, 1, 0, 1, 2, 16'h0000, (D1 == 5'd1) ? 5'h00 : 5'h1E, 1, 2, 0)); // equal fields

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].sw, vecs[i].op, vecs[i].sel, vecs[i].d);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_v, vecs[i].e_idx, vecs[i].e_busy);
        end

        hand_sweep("sweep_f8e9", 16'hF8E9, 1'b0, 5'h17, 5'h11, 5'h18);
`ifdef DATA_CAL_SWEEP_ABSDIFF_EN
        hand_sweep("sweep_diff", 16'hF8E9, 1'b1, 5'h05, 5'h01, 5'h06);
`else
        hand_sweep("sweep_diff", 16'hF8E9, 1'b1, 5'h17, 5'h11, 5'h18);
`endif
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 16'h0);
        @(posedge clk); #1;
        check("post_sweep_op", 5'h18, 1'b1, 2'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
